// File: rtl/stream_delay_line_pkg.sv
// Shared types for the stream delay line: FSM state encoding and the
// width helper for the optional occupancy output (STREAM_DELAY_LEVEL_EN).
package stream_delay_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Bits needed to count 0..depth inclusive.
    function automatic int levelWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_delay_line_shift_register.sv
// Enable-gated DEPTH x WIDTH shift register; stage 0 takes data_i and the
// last stage drives data_o. Active-low asynchronous reset clears all stages.
module shift_register
    import stream_delay_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= {stage_q[DEPTH-2:0], data_i};
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/stream_delay_line.sv
// Valid/ready stage delaying a stream by exactly DEPTH accepted beats, with a
// drain-on-flush mode. Define STREAM_DELAY_LEVEL_EN to add the 'level' output.
module stream_delay_line
    import stream_delay_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef STREAM_DELAY_LEVEL_EN
    output logic [levelWidth(DEPTH)-1:0] level,
`endif
    input  logic             flush
);

    state_e           state_q, state_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic             sh;
    logic             vldIn;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sh        = 1'b0;
        vldIn     = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                sh       = in_valid;
                vldIn    = 1'b1;
                // vld_q[DEPTH-2] set means this shift fills the last stage.
                if (flush) begin
                    state_d = FLUSH;
                end else if (sh && vld_q[DEPTH-2]) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                sh        = in_valid & out_ready;
                vldIn     = 1'b1;
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                out_valid = vld_q[DEPTH-1];
                sh        = ~vld_q[DEPTH-1] | out_ready;
                vldIn     = 1'b0;
                if (vld_q == '0) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign vld_d = sh ? {vld_q[DEPTH-2:0], vldIn} : vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
        end
    end

    shift_register #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_data (
        .clk_i  (clk),
        .rst_ni (~rst),
        .en_i   (sh),
        .data_i (in_data),
        .data_o (out_data)
    );

`ifdef STREAM_DELAY_LEVEL_EN
    localparam int LW = levelWidth(DEPTH);

    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case (state_q)
            FILL:    if (sh) level_d = level_q + LW'(1);
            RUN:     level_d = LW'(DEPTH);
            FLUSH:   if (vld_q[DEPTH-1] && out_ready) level_d = level_q - LW'(1);
            default: level_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: tb/tb_stream_delay_line.sv
// Directed bench for stream_delay_line at DEPTH=4, WIDTH=8; level checks are
// compiled in only when STREAM_DELAY_LEVEL_EN is defined.
module tb_stream_delay_line;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
`ifdef STREAM_DELAY_LEVEL_EN
    logic [2:0]       level;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_delay_line #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STREAM_DELAY_LEVEL_EN
        .level     (level),
`endif
        .flush     (flush)
    );

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expInReady,
                               input logic expOutValid, input logic [WIDTH-1:0] expData,
                               input logic chkData);
        vectors++;
        assert (in_ready === expInReady) else begin
            miscompares++;
            $error("FAIL %s in_ready observed %b expected %b", tag, in_ready, expInReady);
        end
        vectors++;
        assert (out_valid === expOutValid) else begin
            miscompares++;
            $error("FAIL %s out_valid observed %b expected %b", tag, out_valid, expOutValid);
        end
        if (chkData) begin
            vectors++;
            assert (out_data === expData) else begin
                miscompares++;
                $error("FAIL %s out_data observed %h expected %h", tag, out_data, expData);
            end
        end
    endtask

`ifdef STREAM_DELAY_LEVEL_EN
    task automatic checkLevel(input string tag, input logic [2:0] expLevel);
        vectors++;
        assert (level === expLevel) else begin
            miscompares++;
            $error("FAIL %s level observed %0d expected %0d", tag, level, expLevel);
        end
    endtask
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("reset", 1'b1, 1'b0, 8'h00, 1'b1);
`ifdef STREAM_DELAY_LEVEL_EN
        checkLevel("reset_level", 3'd0);
`endif
        #10;
        rst = 1'b0;

        // Prime with four beats; out_valid only after the fourth is taken
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0); checkOutput("prime0", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0); checkOutput("prime1", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0); checkOutput("prime2", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0); checkOutput("prime3", 1'b1, 1'b0, 8'h00, 1'b0); tick;

        applyStimulus(1'b1, 8'h55, 1'b1, 1'b0); checkOutput("stream0", 1'b1, 1'b1, 8'h11, 1'b1); tick;
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b0); checkOutput("stream1", 1'b1, 1'b1, 8'h22, 1'b1); tick;

        // Backpressure: nothing moves while out_ready is low
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
            checkOutput($sformatf("bp%0d", i), 1'b0, 1'b1, 8'h33, 1'b1);
            tick;
        end

        // Full flush of 0x33..0x66; in_valid is low so contents are unchanged
        applyStimulus(1'b0, 8'h77, 1'b1, 1'b1); checkOutput("flushReq", 1'b1, 1'b1, 8'h33, 1'b1); tick;
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0); checkOutput("flush0", 1'b0, 1'b1, 8'h33, 1'b1); tick;
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b0); checkOutput("flushHold", 1'b0, 1'b1, 8'h44, 1'b1); tick;
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b1); checkOutput("flush1", 1'b0, 1'b1, 8'h44, 1'b1); tick;
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0); checkOutput("flush2", 1'b0, 1'b1, 8'h55, 1'b1); tick;
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0); checkOutput("flush3", 1'b0, 1'b1, 8'h66, 1'b1); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("flushEmpty", 1'b0, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("flushDone", 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef STREAM_DELAY_LEVEL_EN
        checkLevel("flushDone_level", 3'd0);
`endif

        // Partial flush with two entries held
        rst = 1'b1; #2; rst = 1'b0;
        applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0); checkOutput("part0", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'hA2, 1'b1, 1'b0); checkOutput("part1", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1); checkOutput("partReq", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0); checkOutput("bubble0", 1'b0, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0); checkOutput("bubble1", 1'b0, 1'b0, 8'h00, 1'b0); tick;
`ifdef STREAM_DELAY_LEVEL_EN
        checkLevel("part_level", 3'd2);
`endif
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0); checkOutput("partOut0", 1'b0, 1'b1, 8'hA1, 1'b1); tick;
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0); checkOutput("partOut1", 1'b0, 1'b1, 8'hA2, 1'b1); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("partEmpty", 1'b0, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("partDone", 1'b1, 1'b0, 8'h00, 1'b0);

        // Flush while already empty: one FLUSH cycle then back to FILL
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1); checkOutput("emptyReq", 1'b1, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0); checkOutput("emptyFlush", 1'b0, 1'b0, 8'h00, 1'b0); tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("emptyDone", 1'b1, 1'b0, 8'h00, 1'b0);

        // Reach RUN, then reset asynchronously mid-cycle
        applyStimulus(1'b1, 8'hB1, 1'b1, 1'b0); tick;
        applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0); tick;
        applyStimulus(1'b1, 8'hB3, 1'b1, 1'b0); tick;
        applyStimulus(1'b1, 8'hB4, 1'b1, 1'b0); tick;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); checkOutput("runB", 1'b0, 1'b1, 8'hB1, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midReset", 1'b1, 1'b0, 8'h00, 1'b1);
`ifdef STREAM_DELAY_LEVEL_EN
        checkLevel("midReset_level", 3'd0);
`endif
        #2;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hC1 + 8'(i), 1'b1, 1'b0);
            checkOutput($sformatf("reprime%0d", i), 1'b1, 1'b0, 8'h00, 1'b0);
`ifdef STREAM_DELAY_LEVEL_EN
            checkLevel($sformatf("reprime%0d_level", i), 3'(i));
`endif
            tick;
        end
        applyStimulus(1'b1, 8'hC5, 1'b1, 1'b0); checkOutput("reprimed", 1'b1, 1'b1, 8'hC1, 1'b1);
`ifdef STREAM_DELAY_LEVEL_EN
        checkLevel("reprimed_level", 3'd4);
`endif
        tick;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); checkOutput("reprimedNext", 1'b1, 1'b1, 8'hC2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
